tt_sweep: RTL and testbench
===========================

# tt_sweep

Sequential truth-table extractor for 7-input single-output Boolean function blocks. It drives all 128 input minterms onto a combinational function-under-test and captures the function's output into a 128-bit truth table. It compares that table with an expected table and pulses `done`. It sits directly upstream of each 7-input function netlist, driving its `x0`..`x6`, and also consumes that netlist's `out`.

## Interface
- `SETTLE`, default 1: clock cycles each minterm is held before its response is sampled; legal range 1..15.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  begin a sweep; honoured only in IDLE
- `abort`  input  1  cancel a sweep in progress
- `expected`  input  128  expected truth table; bit k = f(minterm k)
- `f_in`  input  1  function-under-test output (its `out`)
- `x0`..`x6`  output  1 each  minterm drive; minterm index k = {x6,x5,x4,x3,x2,x1,x0}
- `busy`  output  1  sweep in progress
- `done`  output  1  one-cycle pulse when a sweep completes
- `tt`  output  128  captured truth table; bit k = f_in sampled for minterm k
- `match`  output  1  `tt == expected`; valid from `done`, held until next start
- `ones`  output  8  number of 1 bits in `tt` (0..128)

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: `x0`..`x6` = 0, `busy` = 0, `done` = 0, `tt` = 0, `match` = 0, `ones` = 0; state = IDLE.
- States and transitions:
  - IDLE: on `start`, clear `tt`, `ones` and `match`; set index = 0 and settle counter = 0; go to SWEEP.
  - SWEEP: drive index on `x*`. When settle counter = SETTLE-1:
    - write `tt[index] <= f_in`;
    - add `f_in` to `ones`;
    - if index = 127, go to CHECK; otherwise increment index (7-bit) and clear the settle counter.
  - CHECK: compute `match` from the complete `tt` and `expected`; pulse `done`; go to IDLE.
- `abort` in SWEEP or CHECK returns the block to IDLE next edge.
  - No `done` pulse; `match` = 0.
  - `tt` and `ones` keep their partial values.
  - `x*` return to 0.
- `abort` has priority over sweep progress. `abort` in IDLE has no effect.
- `start` while `busy` is ignored. Simultaneous `start` and `abort` in IDLE: the sweep starts.
- `expected` is sampled only in CHECK; it may change during SWEEP.
- `ones` saturates by construction: 128 fits in 8 bits, so no wrap.
- Reset mid-sweep forces the reset values immediately, asynchronously.

## Timing
- Edge 0 is the edge at which `start` is seen in IDLE. `busy` is high from edge 0.
- Minterm k is driven during cycles k·SETTLE+1 .. (k+1)·SETTLE. It is sampled at edge (k+1)·SETTLE.
- The last sample is at edge 128·SETTLE. At edge 128·SETTLE+1:
  - `done` = 1 for one cycle;
  - `match` is valid;
  - `busy` = 0.
- Back-to-back: `start` may be asserted in the cycle `done` is high. It is honoured at the following edge, because the block is already in IDLE.
- `tt` and `ones` update incrementally, one bit per sample edge; their final value is stable from the last sample edge onward.
- `f_in` must be settled one setup time before each sample edge. This is guaranteed for SETTLE-cycle-deep combinational paths.

## Configuration
- `TT_SWEEP_POPCOUNT_EN` defined: the `ones` accumulator is built as described above.
- Not defined: the `ones` port remains but is tied to 0; the accumulator logic is removed. All other behaviour is identical.

## Test plan
- f = 3-input majority of x0,x1,x2, SETTLE=1, `expected` = 128'hE8 repeated ×16, pulse `start` → `done` at edge 129; `tt` = `expected`; `match` = 1; `ones` = 64.
- f = constant 0, `expected` = 128'h1 → `tt` = 0; `match` = 0; `ones` = 0.
- f = x6, SETTLE=3 → `done` at edge 385; `tt` = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}; `ones` = 64; each minterm held exactly 3 cycles on `x*`.
- Assert `abort` at edge 40 → `busy` low at edge 41; no `done`; `x*` = 0. A new `start` then produces a full sweep with correct `tt`.
- Pulse `start` at edge 10 mid-sweep → ignored; `done` still at edge 129. Hold `start` high through `done` → second sweep begins at the edge after `done`.
- Assert `rst_n` low at edge 60 → all outputs 0 immediately, before the next clock edge. After reset is released, a sweep with f = x0 gives `tt` = 128'hAAAA…AAAA and `ones` = 64.

Source files
------------

// File: rtl/tt_sweep_if.sv
// tt_sweep_if: control/status bundle between a sweep requester and tt_sweep.
//
// Handshake: `start` is a level request that is honoured only on an edge where
// the sweeper is idle (busy == 0). There is no backpressure. `busy` is high
// from the accepting edge until the sweep ends. `done` is a single-cycle pulse
// that marks a completed sweep. `tt`, `ones` and `match` are status registers.
// `match` is valid from `done` and is held until the next accepted start.
interface tt_sweep_if;
    logic         start;
    logic         abort;
    logic [127:0] expected;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic         match;
    logic [7:0]   ones;

    modport master (
        output start, abort, expected,
        input  busy, done, tt, match, ones
    );

    modport slave (
        input  start, abort, expected,
        output busy, done, tt, match, ones
    );
endinterface

// File: rtl/tt_sweep.sv
// tt_sweep: drives all 128 minterms of a 7-input combinational function,
// captures its response into a truth table and compares the table with an
// expected one.
// Optional feature macro: TT_SWEEP_POPCOUNT_EN. When it is defined, the
// running count of 1 bits is built. When it is not defined, `ones` is tied
// to 0.
// SETTLE (1..15) is the number of cycles each minterm is held before its
// response is sampled.
module tt_sweep #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    tt_sweep_if.slave   bus,
    input  logic        f_in,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        x5,
    output logic        x6,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [6:0]   idx_q;
    logic [3:0]   cnt_q;
    logic [127:0] tt_q;
    logic         match_q;
    logic         done_q;
    logic         sample;
    logic [6:0]   drive;

    // The response is sampled on the last settle cycle of each minterm.
    assign sample = (state_q == SWEEP) && (cnt_q == SETTLE_LAST);

    // Next-state logic. abort wins over sweep progress, and it is ignored in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP: begin
                if (bus.abort)                        state_d = IDLE;
                else if (sample && idx_q == 7'd127)   state_d = CHECK;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Minterm index, settle counter, truth table, match flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (bus.abort) begin
                        // Partial tt is kept so that the failing point can be inspected.
                        match_q <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else if (sample) begin
                        tt_q[idx_q] <= f_in;
                        cnt_q       <= '0;
                        if (idx_q != 7'd127) idx_q <= idx_q + 7'd1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                CHECK: begin
                    // expected is looked at only here, so it may change during SWEEP.
                    if (bus.abort) begin
                        match_q <= 1'b0;
                    end else begin
                        match_q <= (tt_q == bus.expected);
                        done_q  <= 1'b1;
                    end
                    idx_q <= '0;
                    cnt_q <= '0;
                end
                default: begin
                    idx_q <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_POPCOUNT_EN
    logic [7:0] ones_q;

    // Running count of 1 bits. The maximum of 128 fits in 8 bits, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            ones_q <= '0;
        end else if (sample && !bus.abort) begin
            ones_q <= ones_q + {7'd0, f_in};
        end
    end

    assign bus.ones = ones_q;
`else
    assign bus.ones = 8'd0;
`endif

    // The minterm is driven only while sweeping. At all other times it is parked at 0.
    assign drive = (state_q == SWEEP) ? idx_q : 7'd0;
    assign {x6, x5, x4, x3, x2, x1, x0} = drive;

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.tt    = tt_q;
    assign bus.match = match_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: checks two tt_sweep instances (SETTLE=1 and SETTLE=3) against a
// truth-table model of the functions under test.
module tb_tt_sweep;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tt_sweep_if bus0();
    tt_sweep_if bus1();

    logic         start_v [2];
    logic         abort_v [2];
    logic [127:0] exp_v   [2];
    int           fsel    [2];
    logic [127:0] rand_tbl;

    logic [6:0]   xv0, xv1;
    logic         f0, f1;
    logic [1:0]   st0, st1;

    assign bus0.start    = start_v[0];
    assign bus0.abort    = abort_v[0];
    assign bus0.expected = exp_v[0];
    assign bus1.start    = start_v[1];
    assign bus1.abort    = abort_v[1];
    assign bus1.expected = exp_v[1];

    logic [127:0] tt_o    [2];
    logic [7:0]   ones_o  [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic         match_o [2];
    logic [6:0]   x_o     [2];
    logic [1:0]   st_o    [2];

    assign tt_o[0] = bus0.tt;     assign tt_o[1] = bus1.tt;
    assign ones_o[0] = bus0.ones; assign ones_o[1] = bus1.ones;
    assign busy_o[0] = bus0.busy; assign busy_o[1] = bus1.busy;
    assign done_o[0] = bus0.done; assign done_o[1] = bus1.done;
    assign match_o[0] = bus0.match; assign match_o[1] = bus1.match;
    assign x_o[0] = xv0;          assign x_o[1] = xv1;
    assign st_o[0] = st0;         assign st_o[1] = st1;

    tt_sweep #(.SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .f_in(f0),
        .x0(xv0[0]), .x1(xv0[1]), .x2(xv0[2]), .x3(xv0[3]),
        .x4(xv0[4]), .x5(xv0[5]), .x6(xv0[6]), .dbg_state(st0)
    );

    tt_sweep #(.SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .f_in(f1),
        .x0(xv1[0]), .x1(xv1[1]), .x2(xv1[2]), .x3(xv1[3]),
        .x4(xv1[4]), .x5(xv1[5]), .x6(xv1[6]), .dbg_state(st1)
    );

    // ---------------- reference model ----------------
    // Function selection: 0 = majority(x0,x1,x2), 1 = const 0, 2 = x6,
    // 3 = x0, other values = arbitrary random table.
    function automatic logic ref_f(input int fs, input logic [6:0] k, input logic [127:0] tbl);
        case (fs)
            0:       return (k[0] & k[1]) | (k[0] & k[2]) | (k[1] & k[2]);
            1:       return 1'b0;
            2:       return k[6];
            3:       return k[0];
            default: return tbl[k];
        endcase
    endfunction

    function automatic logic [127:0] ref_table(input int fs, input logic [127:0] tbl);
        logic [127:0] t;
        t = '0;
        for (int k = 0; k < 128; k++) t[k] = ref_f(fs, 7'(k), tbl);
        return t;
    endfunction

    function automatic logic [7:0] ref_ones(input logic [127:0] t);
`ifdef TT_SWEEP_POPCOUNT_EN
        return 8'($countones(t));
`else
        return 8'd0;
`endif
    endfunction

    always_comb f0 = ref_f(fsel[0], xv0, rand_tbl);
    always_comb f1 = ref_f(fsel[1], xv1, rand_tbl);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Waits until done, counting edges after edge 0. At every edge before the
    // last sample, it checks that x shows the minterm cnt/s.
    task automatic wait_done(input int sel, input int s, input int mid_start,
                             input bit hold, output int cnt, output int xerr);
        cnt  = 0;
        xerr = 0;
        while (cnt < 128 * s + 20) begin
            if (mid_start > 0 && cnt == mid_start - 1) start_v[sel] = 1'b1;
            if (mid_start > 0 && cnt == mid_start && !hold) start_v[sel] = 1'b0;
            @(posedge clk); #1;
            cnt++;
            if (cnt < 128 * s && x_o[sel] !== 7'(cnt / s)) xerr++;
            if (done_o[sel] === 1'b1) break;
        end
    endtask

    task automatic check_result(input int sel, input int s, input int cnt, input int xerr,
                                input logic [127:0] exp_tt);
        check("done_edge", 128'(cnt), 128'(128 * s + 1));
        check("x_seq", 128'(xerr), 128'd0);
        check("busy_at_done", 128'(busy_o[sel]), 128'd0);
        check("tt", tt_o[sel], exp_tt);
        check("ones", 128'(ones_o[sel]), 128'(ref_ones(exp_tt)));
        check("match", 128'(match_o[sel]), 128'(exp_tt == exp_v[sel]));
    endtask

    task automatic run_sweep(input int sel, input int s, input int mid_start,
                             input bit hold, input bit with_abort);
        int cnt, xerr;
        logic [127:0] exp_tt;
        exp_tt = ref_table(fsel[sel], rand_tbl);
        @(negedge clk);
        start_v[sel] = 1'b1;
        abort_v[sel] = with_abort;
        @(posedge clk); #1;
        check("busy_e0", 128'(busy_o[sel]), 128'd1);
        check("x_e0", 128'(x_o[sel]), 128'd0);
        abort_v[sel] = 1'b0;
        if (!hold) start_v[sel] = 1'b0;
        wait_done(sel, s, mid_start, hold, cnt, xerr);
        check_result(sel, s, cnt, xerr, exp_tt);
        @(posedge clk); #1;
        check("done_pulse", 128'(done_o[sel]), 128'd0);
        check("restart", 128'(busy_o[sel]), 128'(hold));
        if (hold) begin
            start_v[sel] = 1'b0;
            wait_done(sel, s, -1, 1'b0, cnt, xerr);
            check_result(sel, s, cnt, xerr, exp_tt);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] part;
        int           nd;
        int           flip;

        start_v[0] = 0; start_v[1] = 0;
        abort_v[0] = 0; abort_v[1] = 0;
        exp_v[0] = '0;  exp_v[1] = '0;
        fsel[0] = 1;    fsel[1] = 1;
        rand_tbl = '0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(busy_o[0]), 128'd0);
        check("rst_done", 128'(done_o[0]), 128'd0);
        check("rst_tt", tt_o[0], 128'd0);
        check("rst_match", 128'(match_o[0]), 128'd0);
        check("rst_ones", 128'(ones_o[0]), 128'd0);
        check("rst_x", 128'(x_o[0]), 128'd0);
        check("rst_state", 128'(st_o[1]), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Majority function with its known table. Start arrives together with abort.
        fsel[0] = 0;
        exp_v[0] = {16{8'hE8}};
        check("maj_model", ref_table(0, rand_tbl), {16{8'hE8}});
        run_sweep(0, 1, -1, 1'b0, 1'b1);

        // Constant 0 against a non-matching expected table.
        fsel[0] = 1;
        exp_v[0] = 128'h1;
        run_sweep(0, 1, -1, 1'b0, 1'b0);

        // f = x6 with SETTLE = 3.
        fsel[1] = 2;
        exp_v[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        run_sweep(1, 3, -1, 1'b0, 1'b0);

        // Abort at edge 40, then a clean sweep.
        fsel[0] = 3;
        exp_v[0] = {32{4'hA}};
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        part = '0;
        for (int k = 0; k < 40; k++) part[k] = ref_f(3, 7'(k), rand_tbl);
        check("abort_busy", 128'(busy_o[0]), 128'd0);
        check("abort_x", 128'(x_o[0]), 128'd0);
        check("abort_match", 128'(match_o[0]), 128'd0);
        check("abort_tt", tt_o[0], part);
        check("abort_ones", 128'(ones_o[0]), 128'(ref_ones(part)));
        nd = 0;
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            if (done_o[0] === 1'b1) nd++;
        end
        check("abort_no_done", 128'(nd), 128'd0);
        run_sweep(0, 1, -1, 1'b0, 1'b0);

        // Start pulsed mid-sweep is ignored. Start held through done restarts.
        run_sweep(0, 1, 10, 1'b0, 1'b0);
        run_sweep(0, 1, -1, 1'b1, 1'b0);

        // Asynchronous reset mid-sweep.
        fsel[0] = 0;
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy_o[0]), 128'd0);
        check("arst_tt", tt_o[0], 128'd0);
        check("arst_ones", 128'(ones_o[0]), 128'd0);
        check("arst_x", 128'(x_o[0]), 128'd0);
        check("arst_done", 128'(done_o[0]), 128'd0);
        check("arst_match", 128'(match_o[0]), 128'd0);
        @(negedge clk); rst_n = 1'b1;
        fsel[0] = 3;
        exp_v[0] = {32{4'hA}};
        run_sweep(0, 1, -1, 1'b0, 1'b0);

        // Random truth tables. Expected is either exact or has one flipped bit.
        for (int it = 0; it < 6; it++) begin
            rand_tbl = {$urandom, $urandom, $urandom, $urandom};
            fsel[0] = 4;
            exp_v[0] = rand_tbl;
            if ($urandom_range(0, 1) == 1) begin
                flip = $urandom_range(0, 127);
                exp_v[0][flip] = ~exp_v[0][flip];
            end
            run_sweep(0, 1, -1, 1'b0, 1'b0);
        end

        // Random table on the SETTLE = 3 instance.
        rand_tbl = {$urandom, $urandom, $urandom, $urandom};
        fsel[1] = 4;
        exp_v[1] = rand_tbl;
        run_sweep(1, 3, -1, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
